// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter : write-back arbiter in front of the 8x16 register file.
//
// Merges ALU results and data-memory load results onto the register file's
// single write port. Loads always win. ALU results that lose are queued in an
// in-order FIFO and drained when no load is present. An empty FIFO with an
// accepted ALU result takes a bypass path straight to the output register.
// A pending-write bitmap lets decode stall on registers still in flight.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   alu_valid   in   ALU result present
//   alu_ready   out  ALU result accepted when alu_valid && alu_ready
//   alu_rd      in   ALU destination register  [AW]
//   alu_result  in   ALU result                [DW]
//   mem_valid   in   load result present (always accepted)
//   mem_rd      in   load destination register [AW]
//   mem_data    in   load data                 [DW]
//   write_en    out  register file write enable (registered)
//   RW          out  register file write address (registered)
//   bus_w       out  register file write data (registered)
//   pending     out  per-register write-in-flight bitmap [2^AW]
//   fifo_count  out  valid-or-killed FIFO entries [AW+1]
//
// Optional feature macro: WB_R0_DISCARD_EN
//   When defined, results targeting register 0 are accepted but dropped:
//   never queued, never written, and a load to r0 does not block a FIFO pop.
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int AW    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [AW-1:0]        alu_rd,
    input  logic [DW-1:0]        alu_result,
    input  logic                 mem_valid,
    input  logic [AW-1:0]        mem_rd,
    input  logic [DW-1:0]        mem_data,
    output logic                 write_en,
    output logic [AW-1:0]        RW,
    output logic [DW-1:0]        bus_w,
    output logic [(1<<AW)-1:0]   pending,
    output logic [AW:0]          fifo_count
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // FIFO storage; a cleared valid bit marks a killed (or free) slot
    logic [AW-1:0]    fifo_rd_q   [DEPTH];
    logic [DW-1:0]    fifo_data_q [DEPTH];
    logic [DEPTH-1:0] fifo_vld_q, fifo_vld_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [AW:0]      count_q, count_d;

    logic             write_en_q, write_en_d;
    logic [AW-1:0]    rw_q, rw_d;
    logic [DW-1:0]    bus_w_q, bus_w_d;

    logic             alu_drop, mem_take;
    logic             alu_acc, fifo_empty, pop, bypass, push;

`ifdef WB_R0_DISCARD_EN
    assign alu_drop = (alu_rd == '0);
    assign mem_take = mem_valid && (mem_rd != '0);
`else
    assign alu_drop = 1'b0;
    assign mem_take = mem_valid;
`endif

    // Ready looks only at the registered count, so a same-cycle pop does not
    // open a slot; this keeps alu_ready free of any path from mem_valid.
    assign alu_ready  = rst_n && (count_q < DEPTH_C);
    assign alu_acc    = alu_valid && alu_ready;
    assign fifo_empty = (count_q == '0);
    assign pop        = !mem_take && !fifo_empty;
    assign bypass     = !mem_take && fifo_empty && alu_acc && !alu_drop;
    assign push       = alu_acc && !alu_drop && !bypass;

    always_comb begin
        fifo_vld_d = fifo_vld_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        // A load is the youngest write to its register: older queued ALU
        // results to the same register must never reach the file after it.
        if (mem_take) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (fifo_rd_q[i] == mem_rd) fifo_vld_d[i] = 1'b0;
            end
        end
        if (pop) begin
            fifo_vld_d[head_q] = 1'b0;
            head_d             = head_q + PW'(1);
        end
        // Applied after the kill so a same-cycle push to mem_rd survives.
        if (push) begin
            fifo_vld_d[tail_q] = 1'b1;
            tail_d             = tail_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        write_en_d = 1'b0;
        rw_d       = rw_q;
        bus_w_d    = bus_w_q;
        if (mem_take) begin
            write_en_d = 1'b1;
            rw_d       = mem_rd;
            bus_w_d    = mem_data;
        end else if (pop) begin
            // Killed head drains as a bubble
            write_en_d = fifo_vld_q[head_q];
            if (fifo_vld_q[head_q]) begin
                rw_d    = fifo_rd_q[head_q];
                bus_w_d = fifo_data_q[head_q];
            end
        end else if (bypass) begin
            write_en_d = 1'b1;
            rw_d       = alu_rd;
            bus_w_d    = alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_vld_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            write_en_q <= 1'b0;
            rw_q       <= '0;
            bus_w_q    <= '0;
        end else begin
            fifo_vld_q <= fifo_vld_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            write_en_q <= write_en_d;
            rw_q       <= rw_d;
            bus_w_q    <= bus_w_d;
        end
    end

    // Payload storage is qualified by the valid bits, so it needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[tail_q]   <= alu_rd;
            fifo_data_q[tail_q] <= alu_result;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld_q[i]) pending[fifo_rd_q[i]] = 1'b1;
        end
        if (write_en_q) pending[rw_q] = 1'b1;
    end

    assign write_en   = write_en_q;
    assign RW         = rw_q;
    assign bus_w      = bus_w_q;
    assign fifo_count = count_q;

endmodule
